// File: rtl/dcmac_rx_axis_adapter.sv
// DCMAC 400G segmented RX stream to a 1024-bit AXI4-Stream. Packets are realigned to byte 0,
// and because the MAC cannot be stalled, packets are truncated or dropped when the FIFO fills.
module dcmac_rx_axis_adapter #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        dcmac_rx_vld,
    input  logic [7:0]                  dcmac_rx_ena,
    input  logic [7:0]                  dcmac_rx_sop,
    input  logic [7:0]                  dcmac_rx_eop,
    input  logic [7:0]                  dcmac_rx_err,
    input  logic [31:0]                 dcmac_rx_mty,
    input  logic [1023:0]               dcmac_rx_dat,
    output logic [1023:0]               m_axis_tdata,
    output logic [127:0]                m_axis_tkeep,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tuser,
    output logic [CNT_W-1:0]            drop_cnt,
    output logic [CNT_W-1:0]            trunc_cnt,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, PKT, DROP_T, DROP_S} mode_e;

    typedef struct packed {
        logic [1023:0] data;
        logic [127:0]  keep;
        logic          last;
        logic          user;
    } beat_t;

    mode_e            mode_q, mode_d;
    logic [1023:0]    acc_q, acc_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] drop_q, trunc_q;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q;
    beat_t            mem [FIFO_DEPTH];

    beat_t            push_beat [2];
    logic [1:0]       push_n, drop_inc, trunc_inc;
    logic [1:0]       wr_en;
    logic             accept, pop;
    beat_t            head;

    function automatic logic [127:0] keep_mask(input logic [7:0] nbytes);
        logic [127:0] m;
        m = '0;
        for (int b = 0; b < 128; b++) m[b] = (8'(b) < nbytes);
        return m;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] inc);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(inc);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    assign accept = (level_q <= (AW+1)'(FIFO_DEPTH - 3));

    // Walk the eight segments in order so that eop-before-sop, sop-inside-a-packet and
    // rejection all fall out of one sequential description.
    // NOTE: always_comb uses blocking '=' so later segments see earlier updates; state regs use '<='.
    always_comb begin
        mode_e         m;
        logic [3:0]    n;
        logic [1023:0] acc;
        beat_t         bt;
        // NOTE: every output of this block gets a default here, so no latch can be inferred.
        m            = mode_q;
        n            = {1'b0, cnt_q};
        acc          = acc_q;
        bt           = '0;
        push_beat[0] = '0;
        push_beat[1] = '0;
        push_n       = '0;
        drop_inc     = '0;
        trunc_inc    = '0;
        if (dcmac_rx_vld) begin
            if (!accept && m == PKT) m = DROP_T;
            for (int i = 0; i < 8; i++) begin
                if (dcmac_rx_ena[i]) begin
                    if (dcmac_rx_sop[i]) begin
                        if (m == PKT || m == DROP_T) begin
                            bt = '{data: acc, keep: (n == 4'd0) ? 128'hFFFF : keep_mask({n, 4'b0}),
                                   last: 1'b1, user: 1'b1};
                            if (push_n != 2'd2) begin push_beat[push_n[0]] = bt; push_n = push_n + 2'd1; end
                            trunc_inc = trunc_inc + 2'd1;
                        end else if (m == DROP_S) begin
                            drop_inc = drop_inc + 2'd1;
                        end
                        acc = '0;
                        n   = '0;
                        m   = accept ? PKT : DROP_S;
                    end
                    if (m == PKT) begin
                        acc[{n[2:0], 7'b0} +: 128] = dcmac_rx_dat[128*i +: 128];
                        n = n + 4'd1;
                        if (dcmac_rx_eop[i]) begin
                            bt = '{data: acc, keep: keep_mask({n, 4'b0} - {4'b0, dcmac_rx_mty[4*i +: 4]}),
                                   last: 1'b1, user: dcmac_rx_err[i]};
                            if (push_n != 2'd2) begin push_beat[push_n[0]] = bt; push_n = push_n + 2'd1; end
                            acc = '0;
                            n   = '0;
                            m   = IDLE;
                        end else if (n == 4'd8) begin
                            bt = '{data: acc, keep: '1, last: 1'b0, user: 1'b0};
                            if (push_n != 2'd2) begin push_beat[push_n[0]] = bt; push_n = push_n + 2'd1; end
                            acc = '0;
                            n   = '0;
                        end
                    end else if (dcmac_rx_eop[i]) begin
                        if (m == DROP_T) begin
                            bt = '{data: acc, keep: (n == 4'd0) ? 128'hFFFF : keep_mask({n, 4'b0}),
                                   last: 1'b1, user: 1'b1};
                            if (push_n != 2'd2) begin push_beat[push_n[0]] = bt; push_n = push_n + 2'd1; end
                            trunc_inc = trunc_inc + 2'd1;
                        end else if (m == DROP_S) begin
                            drop_inc = drop_inc + 2'd1;
                        end
                        acc = '0;
                        n   = '0;
                        m   = IDLE;
                    end
                end
            end
        end
        mode_d = m;
        acc_d  = acc;
        cnt_d  = n[2:0];
    end

    // The acceptance threshold already guarantees room; the guard only protects the pointers.
    assign wr_en[0] = (push_n != 2'd0) && (level_q < (AW+1)'(FIFO_DEPTH));
    assign wr_en[1] = (push_n == 2'd2) && (level_q < (AW+1)'(FIFO_DEPTH - 1));

    assign m_axis_tvalid = (level_q != '0);
    assign pop           = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q   <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            drop_q   <= '0;
            trunc_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mode_q   <= mode_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            drop_q   <= sat_add(drop_q, drop_inc);
            trunc_q  <= sat_add(trunc_q, trunc_inc);
            wr_ptr_q <= wr_ptr_q + AW'(wr_en[0]) + AW'(wr_en[1]);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            level_q  <= level_q + (AW+1)'(wr_en[0]) + (AW+1)'(wr_en[1]) - (AW+1)'(pop);
        end
    end

    // NOTE: the storage array has no reset; outputs are masked by tvalid so stale entries never show.
    always_ff @(posedge clk) begin
        if (wr_en[0]) mem[wr_ptr_q]          <= push_beat[0];
        if (wr_en[1]) mem[wr_ptr_q + AW'(1)] <= push_beat[1];
    end

    assign head         = m_axis_tvalid ? mem[rd_ptr_q] : '0;
    assign m_axis_tdata = head.data;
    assign m_axis_tkeep = head.keep;
    assign m_axis_tlast = head.last;
    assign m_axis_tuser = head.user;
    assign drop_cnt     = drop_q;
    assign trunc_cnt    = trunc_q;
    assign fifo_level   = level_q;
endmodule
